// File: rtl/mod_sub_serial.sv
// Word-serial modular subtractor: diff = (a - b) mod P, one W-bit limb per clock.
// A raw subtract pass runs first; P is added back in a second pass only when it underflowed.
module mod_sub_serial #(
    parameter int unsigned   N = 256,
    parameter int unsigned   W = 32,
    parameter logic [N-1:0]  P = {1'b0, {(N-1){1'b1}}} - N'(18)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int unsigned K  = N / W;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  a_q, b_q, work_q, diff_q;
    logic [IW-1:0] idx_q;
    logic          c_q, borrow_q, in_ready_q, out_valid_q;

    logic [W:0]    sum_d;
    logic [N-1:0]  shifted_d;

    // Both passes share one limb datapath; operands shift down, results shift in from the top.
    always_comb begin
        sum_d = '0;
        if (state_q == FIX) begin
            sum_d = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, c_q};
        end else begin
            sum_d = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - {{W{1'b0}}, c_q};
        end
        shifted_d = {sum_d[W-1:0], work_q[N-1:W]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            c_q         <= 1'b0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        idx_q      <= '0;
                        c_q        <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= SUB;
                    end
                end
                SUB: begin
                    work_q <= shifted_d;
                    a_q    <= a_q >> W;
                    b_q    <= b_q >> W;
                    c_q    <= sum_d[W];
                    if (idx_q == LAST) begin
                        idx_q <= '0;
                        if (sum_d[W]) begin
                            // Underflow: the wrapped difference becomes the addend for the P pass.
                            a_q     <= shifted_d;
                            b_q     <= P;
                            c_q     <= 1'b0;
                            state_q <= FIX;
                        end else begin
                            diff_q      <= shifted_d;
                            borrow_q    <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                FIX: begin
                    work_q <= shifted_d;
                    a_q    <= a_q >> W;
                    b_q    <= b_q >> W;
                    c_q    <= sum_d[W];
                    if (idx_q == LAST) begin
                        // Carry out of the top limb is dropped; it cancels the earlier wrap.
                        idx_q       <= '0;
                        c_q         <= 1'b0;
                        diff_q      <= shifted_d;
                        borrow_q    <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: doc/mod_sub_serial.md
Name: mod_sub_serial

Overview:
- Word-serial modular subtractor for the 256-bit field datapath; computes diff = (a - b) mod P with P = 2^255 - 19 by default.
- Complements the combinational adders. Processes one W-bit limb per clock, so a 256-bit subtract costs W-bit carry logic instead of a 256-bit ripple chain.
- Sits between field-element registers and downstream arithmetic.
- Uses a valid/ready handshake on both input and output.

Parameters:
- N, 256, operand/result width in bits. N % W == 0 is required.
- W, 32, limb width processed per cycle.
- P, 2^255-19 (N bits), field modulus. Both inputs must be < P.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/b operands valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend, must be < P.
- b  input  N  subtrahend, must be < P.
- out_valid  output  1  diff/borrow valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  N  (a - b) mod P, always in [0, P).
- borrow  output  1  1 iff a < b (raw subtraction underflowed and P was added back).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, in_ready = 1, out_valid = 0, diff = 0, borrow = 0, limb index = 0, carry/borrow register = 0.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE, SUB, FIX, DONE. K = N/W.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture a and b into internal registers, clear limb index and borrow register, go to SUB.
- SUB (K cycles): on each edge, for limb i:
  - diff[i] = a[i] - b[i] - br, with br the borrow from limb i-1 (br = 0 for limb 0).
  - Store the new borrow.
  - After limb K-1: if the final borrow = 0, go to DONE with borrow = 0. If the final borrow = 1, set borrow = 1, clear the carry register and index, go to FIX.
- FIX (K cycles): on each edge, for limb i:
  - diff[i] = diff[i] + P[i] + c, with c the carry from limb i-1 (c = 0 for limb 0).
  - Drop the carry out of limb K-1 (it is always 1, cancelling the wrap).
  - After limb K-1, go to DONE.
- DONE:
  - out_valid = 1; diff and borrow are held stable.
  - On out_ready, go to IDLE next edge with out_valid = 0. diff/borrow keep their last value until the next result overwrites them.
- in_ready = 1 only in IDLE. Operations never overlap, and a new input is not accepted in the same cycle a result is consumed.
- Latency, counted from the acceptance edge to the first cycle out_valid is high:
  - K edges if a >= b (8 for defaults).
  - 2K edges if a < b (16 for defaults).
- Width rules:
  - Limb arithmetic is W+1 bits; bit W is the borrow/carry.
  - No other state exceeds N bits.
  - Inputs >= P give undefined results; no checking is performed.
- Backpressure: with out_ready held low, DONE persists indefinitely, diff is unchanged, and in_ready stays 0.
- in_valid asserted outside IDLE is ignored. The source must hold a/b/in_valid until in_ready.

Test Plan:
- a=10, b=3 -> diff=7, borrow=0, out_valid 8 edges after acceptance.
- a=3, b=10 -> diff=P-7=2^255-26, borrow=1, out_valid 16 edges after acceptance.
- Limb-boundary borrow and equal operands:
  - a=2^32, b=1 -> diff=0xFFFFFFFF, borrow=0.
  - a=b=P-1 -> diff=0, borrow=0.
  - a=0, b=P-1 -> diff=1, borrow=1.
- Backpressure:
  - out_ready low for 5 cycles in DONE -> diff/out_valid stable and in_ready=0 throughout.
  - out_ready high -> in_ready=1 the next cycle.
  - Back-to-back ops: a=5, b=2, then a=2, b=5 -> diffs 3, then P-3.
- Reset mid-operation: assert rst during SUB at limb 4 -> out_valid=0, diff=0, borrow=0, in_ready=1 immediately. The next op a=9, b=4 -> diff=5 with normal latency.
- Randomized: 1000 pairs with a, b < P against the reference model (a - b) mod P -> exact match on diff and borrow, and latency of 8 or 16 according to borrow.
